md_engine: RTL

- Multi-cycle multiply/divide responder for the E stage. It accepts a start/op request with the E-stage forwarded operands, runs for a fixed number of cycles, then commits results to the architectural HI/LO registers.
- Drives busy back to the hazard unit, which stalls dependent MD instructions in D.
- Also services mthi/mtlo writes and exposes HI/LO for mfhi/mflo.

---
 rtl/md_engine_if.sv | 34 +++
 rtl/md_engine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/md_engine_if.sv
// Handshake/data bundle between the E stage and md_engine.
// Optional cancel line present when MD_ENGINE_CANCEL_EN is defined.
interface md_engine_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
`ifdef MD_ENGINE_CANCEL_EN
  logic        cancel;
`endif
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
`ifdef MD_ENGINE_CANCEL_EN
    output cancel,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
`ifdef MD_ENGINE_CANCEL_EN
    input  cancel,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/md_engine.sv
// Multi-cycle mult/div responder owning architectural HI/LO.
// Define MD_ENGINE_CANCEL_EN to add the cancel (flush) input on the interface.
module md_engine #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk,
  input logic        reset,
  md_engine_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state_q;
  logic [3:0]  count_q;
  logic [31:0] res_hi_q;
  logic [31:0] res_lo_q;
  logic        res_commit_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        kill;
`ifdef MD_ENGINE_CANCEL_EN
  assign kill = bus.cancel;
`else
  assign kill = 1'b0;
`endif

  logic [63:0] prod;
  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        div_zero;

  // Signed division works on magnitudes so that 0x80000000 / -1 wraps
  // to 0x80000000 instead of overflowing a native signed divide.
  always_comb begin
    sgn = ~bus.op[0];
    if (sgn) prod = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    else     prod = {32'd0, bus.a} * {32'd0, bus.b};
    mag_a    = (sgn && bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    mag_b    = (sgn && bus.b[31]) ? (32'd0 - bus.b) : bus.b;
    div_zero = bus.op[1] && (bus.b == '0);
    div_b    = (bus.b == '0) ? 32'd1 : mag_b;
    quo_u    = mag_a / div_b;
    rem_u    = mag_a % div_b;
    quo      = (sgn && (bus.a[31] ^ bus.b[31])) ? (32'd0 - quo_u) : quo_u;
    rem      = (sgn && bus.a[31]) ? (32'd0 - rem_u) : rem_u;
    calc_hi  = bus.op[1] ? rem : prod[63:32];
    calc_lo  = bus.op[1] ? quo : prod[31:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      res_hi_q     <= '0;
      res_lo_q     <= '0;
      res_commit_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (!kill) begin
              res_hi_q     <= calc_hi;
              res_lo_q     <= calc_lo;
              res_commit_q <= ~div_zero;
              count_q      <= bus.op[1] ? DIV_N : MULT_N;
              busy_q       <= 1'b1;
              state_q      <= RUN;
            end
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end
        RUN: begin
          if (kill) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (count_q == 4'd1) begin
            if (res_commit_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
